hex_display_scanner: RTL and testbench
======================================

# hex_display_scanner

Time-multiplexed scan controller for the calculator's multi-digit seven-segment display. It shares one four-bit-to-seven-segment decoder among all digit positions by presenting one nibble at a time to the decoder and driving the matching active-low digit enable. It holds a frame-synchronous shadow copy of the displayed value, so the display does not tear when the datapath updates. It sits between the calculator result register and the board's HEX/anode pins.

## Interface
- `DIGITS`, 4: number of digit positions scanned; must be at least 2.
- `SCAN_DIV`, 50000: clock cycles each digit stays lit; must be at least 2. The prescaler is `$clog2(SCAN_DIV)` bits wide.
- `clk` in 1: single system clock. All state changes on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `load` in 1: single-cycle strobe; captures `value` on the same edge.
- `value` in 4*DIGITS: hex value to display. Nibble k drives digit k; digit 0 is least significant.
- `dig_bin` out 4: nibble fed to the shared decoder's `bin` input.
- `dig_sel_n` out DIGITS: active-low one-hot digit enable.
- `dig_blank` out 1: 1 = blank the current digit (gate the decoder output to all-off).
- `frame_done` out 1: one-cycle pulse when the last digit's slot ends.
- `pending` out 1: a loaded value is waiting for the next frame boundary.

## Operation
- Registers:
  - prescaler `pre`, 0..SCAN_DIV-1
  - digit index `idx`, 0..DIGITS-1
  - display register `disp`
  - pending register `pbuf`
  - `pending` flag
- Tick: `pre == SCAN_DIV-1`. On a tick, `pre` goes to 0 and `idx` advances. Otherwise `pre` increments.
- Wrap: a tick with `idx == DIGITS-1`. On wrap, `idx` goes to 0 and `frame_done` is 1 for that cycle.
- Load without wrap:
  - `pbuf` takes `value` and `pending` goes to 1.
  - A second load before the wrap overwrites `pbuf`; the last load wins.
- Wrap with `pending == 1` and no load in the same cycle: `disp` takes `pbuf` and `pending` clears.
- Load and wrap in the same cycle: `disp` takes `value` directly. `pending` clears and `pbuf` is unchanged.
- Output registers update every cycle from the next-state `idx` and `disp`:
  - `dig_sel_n` = ~(1 << idx)
  - `dig_bin` = `disp[4*idx +: 4]`
  - `dig_blank` = blank rule for digit `idx` (see Configuration)
- Exactly one bit of `dig_sel_n` is low at all times after the first clock following reset.
- The prescaler runs freely. `load` never resets `pre` or `idx`.

## Timing
- Reset values (asynchronous):
  - `pre` = 0, `idx` = 0, `disp` = 0, `pbuf` = 0, `pending` = 0
  - `dig_sel_n` = all ones, `dig_bin` = 0, `dig_blank` = 0, `frame_done` = 0
- First clock after `rst_n` rises: `dig_sel_n` = ~1 and `dig_bin` = `disp[3:0]`.
- Each digit is lit for exactly SCAN_DIV cycles. A full frame is DIGITS*SCAN_DIV cycles.
- `dig_sel_n`, `dig_bin` and `dig_blank` change together on the same edge, so there is no skew between enable and data.
- Load-to-display latency:
  - Minimum: 1 cycle, when the load lands on a wrap cycle.
  - Maximum: DIGITS*SCAN_DIV cycles.
  - New data first appears on digit 0 at the frame start.
- `frame_done` is registered. It is high in the cycle in which `dig_sel_n` first selects digit 0 of the new frame.
- `rst_n` asserted mid-frame: everything returns to reset values immediately and any pending value is discarded.

## Configuration
- Macro: `HEX_SCAN_LZ_BLANK_EN`.
- Defined: leading-zero blanking.
  - `dig_blank` = 1 for digit k when k > 0 and every nibble of `disp` from k up to DIGITS-1 is zero.
  - Digit 0 is never blanked, so a value of 0 shows a single "0".
- Undefined: `dig_blank` is tied to 0 and no blanking logic is synthesised.

## Test plan
All scenarios use DIGITS=4 and SCAN_DIV=4.
- Reset, then free run with no load:
  - `dig_sel_n` cycles 1110, 1101, 1011, 0111, each held 4 cycles.
  - `dig_bin` = 0 throughout.
  - `frame_done` pulses every 16 cycles.
- Load 16'hA3F7 mid-frame:
  - `pending` goes to 1 and `dig_bin` keeps showing 0 until the wrap.
  - Next frame shows 7, F, 3, A on digits 0..3; `pending` goes to 0.
- Load 16'h1234 then 16'h5678 in the same frame: next frame shows only 8, 7, 6, 5; 1234 never appears.
- Load 16'h00C0 on the exact wrap cycle:
  - The next cycle shows digit 0 = 0 and `pending` stays 0.
  - With `HEX_SCAN_LZ_BLANK_EN`: `dig_blank` = 1 on digits 2 and 3 only.
  - Without it: `dig_blank` = 0 on every digit.
- Load 16'h0000 with `HEX_SCAN_LZ_BLANK_EN`: `dig_blank` = 1 for digits 1..3 and 0 for digit 0, which shows 0.
- Assert `rst_n` = 0 while digit 2 is lit with `pending` = 1:
  - All outputs take their reset values asynchronously.
  - After release, scanning restarts at digit 0 with `disp` = 0.

Source files
------------

// File: rtl/hex_display_scanner.sv
// Time-multiplexed seven-segment scan controller with a frame-synchronous shadow of the displayed value.
// Optional leading-zero blanking is enabled by defining HEX_SCAN_LZ_BLANK_EN.
module hex_display_scanner #(
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 50000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value,
  output logic [3:0]            dig_bin,
  output logic [DIGITS-1:0]     dig_sel_n,
  output logic                  dig_blank,
  output logic                  frame_done,
  output logic                  pending
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam int IW = $clog2(DIGITS);
  localparam logic [PW-1:0] PRE_LAST = PW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

  logic [PW-1:0]       pre, pre_nxt;
  logic [IW-1:0]       idx, idx_nxt;
  logic [4*DIGITS-1:0] disp, disp_nxt, pbuf;
  logic                tick, wrap;

  // Outputs are registered from next-state values so enable and data never skew.
  always_comb begin
    tick     = (pre == PRE_LAST);
    wrap     = tick && (idx == IDX_LAST);
    pre_nxt  = tick ? '0 : pre + 1'b1;
    idx_nxt  = idx;
    if (tick) idx_nxt = wrap ? '0 : idx + 1'b1;
    disp_nxt = disp;
    if (wrap) begin
      if (load)         disp_nxt = value;
      else if (pending) disp_nxt = pbuf;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre        <= '0;
      idx        <= '0;
      disp       <= '0;
      pbuf       <= '0;
      pending    <= 1'b0;
      frame_done <= 1'b0;
      dig_sel_n  <= '1;
      dig_bin    <= 4'h0;
    end else begin
      pre        <= pre_nxt;
      idx        <= idx_nxt;
      disp       <= disp_nxt;
      frame_done <= wrap;
      if (load && !wrap) begin
        pbuf    <= value;
        pending <= 1'b1;
      end else if (wrap) begin
        pending <= 1'b0;
      end
      dig_sel_n <= ~(DIGITS'(1) << idx_nxt);
      dig_bin   <= disp_nxt[4*idx_nxt +: 4];
    end
  end

`ifdef HEX_SCAN_LZ_BLANK_EN
  logic [DIGITS-1:0] lz;
  logic              blank_nxt;

  // lz[k] is set when every nibble from k up to the top digit is zero.
  always_comb begin
    lz = '0;
    lz[DIGITS-1] = (disp_nxt[4*(DIGITS-1) +: 4] == 4'h0);
    for (int k = DIGITS - 2; k >= 0; k--) begin
      lz[k] = lz[k+1] && (disp_nxt[4*k +: 4] == 4'h0);
    end
    blank_nxt = (idx_nxt != '0) && lz[idx_nxt];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) dig_blank <= 1'b0;
    else        dig_blank <= blank_nxt;
  end
`else
  assign dig_blank = 1'b0;
`endif

endmodule

// File: tb/tb_hex_display_scanner.sv
// Self-checking bench for hex_display_scanner (DIGITS=4, SCAN_DIV=4): directed vector table,
// a mid-frame reset sequence, then randomized loads against a frame-arithmetic reference model.
module tb_hex_display_scanner;

  localparam int DIGITS   = 4;
  localparam int SCAN_DIV = 4;
  localparam int FRAME    = DIGITS * SCAN_DIV;
`ifdef HEX_SCAN_LZ_BLANK_EN
  localparam bit LZ = 1'b1;
`else
  localparam bit LZ = 1'b0;
`endif

  typedef struct {
    int          n;
    logic        ld;
    logic [15:0] val;
    logic [3:0]  sel_n;
    logic [3:0]  bin;
    logic        blank_lz;
    logic        pend;
    logic        fd;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load = 1'b0;
  logic [15:0] value = 16'h0;
  logic [3:0]  dig_bin;
  logic [3:0]  dig_sel_n;
  logic        dig_blank;
  logic        frame_done;
  logic        pending;

  int checks = 0;
  int failures = 0;

  // Reference model state: edges since reset release plus displayed/buffered values.
  int          e;
  logic [15:0] m_disp, m_pbuf;
  logic        m_pend, m_fd;

  hex_display_scanner #(.DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .value(value),
    .dig_bin(dig_bin), .dig_sel_n(dig_sel_n), .dig_blank(dig_blank),
    .frame_done(frame_done), .pending(pending)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(int n, logic ld, logic [15:0] v, logic [3:0] sel, logic [3:0] bin,
                              logic blz, logic pend, logic fd);
    vec_t r;
    r.n = n; r.ld = ld; r.val = v; r.sel_n = sel; r.bin = bin;
    r.blank_lz = blz; r.pend = pend; r.fd = fd;
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic ld, input logic [15:0] v);
    load  = ld;
    value = v;
    @(posedge clk);
    #1;
    load = 1'b0;
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, " sel_n"}, 16'(dig_sel_n), 16'hF);
    checkOutput({tag, " bin"}, 16'(dig_bin), 16'h0);
    checkOutput({tag, " blank"}, 16'(dig_blank), 16'h0);
    checkOutput({tag, " frame_done"}, 16'(frame_done), 16'h0);
    checkOutput({tag, " pending"}, 16'(pending), 16'h0);
  endtask

  task automatic modelReset();
    e = 0; m_disp = 16'h0; m_pbuf = 16'h0; m_pend = 1'b0; m_fd = 1'b0;
  endtask

  task automatic modelStep(input logic ld, input logic [15:0] v);
    logic w;
    e++;
    w = (e % FRAME == 0);
    if (ld) begin
      if (w) begin m_disp = v; m_pend = 1'b0; end
      else   begin m_pbuf = v; m_pend = 1'b1; end
    end else if (w && m_pend) begin
      m_disp = m_pbuf;
      m_pend = 1'b0;
    end
    m_fd = w;
  endtask

  task automatic checkModel(input int cyc);
    int          d;
    logic [15:0] upper;
    d = (e / SCAN_DIV) % DIGITS;
    upper = m_disp >> (4 * d);
    checkOutput($sformatf("rnd%0d sel_n", cyc), 16'(dig_sel_n), 16'(4'hF & ~(4'h1 << d)));
    checkOutput($sformatf("rnd%0d bin", cyc), 16'(dig_bin), upper & 16'hF);
    checkOutput($sformatf("rnd%0d blank", cyc), 16'(dig_blank), 16'(LZ && d > 0 && upper == 16'h0));
    checkOutput($sformatf("rnd%0d pending", cyc), 16'(pending), 16'(m_pend));
    checkOutput($sformatf("rnd%0d frame_done", cyc), 16'(frame_done), 16'(m_fd));
  endtask

  initial begin
    vec_t tbl[$];
    tbl.push_back(mk(1, 0, 16'h0,    4'b1110, 4'h0, 0, 0, 0));
    tbl.push_back(mk(3, 0, 16'h0,    4'b1101, 4'h0, 1, 0, 0));
    tbl.push_back(mk(4, 0, 16'h0,    4'b1011, 4'h0, 1, 0, 0));
    tbl.push_back(mk(4, 0, 16'h0,    4'b0111, 4'h0, 1, 0, 0));
    tbl.push_back(mk(3, 0, 16'h0,    4'b0111, 4'h0, 1, 0, 0));
    tbl.push_back(mk(1, 0, 16'h0,    4'b1110, 4'h0, 0, 0, 1));
    tbl.push_back(mk(1, 0, 16'h0,    4'b1110, 4'h0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 16'hA3F7, 4'b1110, 4'h0, 0, 1, 0));
    tbl.push_back(mk(9, 0, 16'h0,    4'b1011, 4'h0, 1, 1, 0));
    tbl.push_back(mk(5, 0, 16'h0,    4'b1110, 4'h7, 0, 0, 1));
    tbl.push_back(mk(4, 0, 16'h0,    4'b1101, 4'hF, 0, 0, 0));
    tbl.push_back(mk(4, 0, 16'h0,    4'b1011, 4'h3, 0, 0, 0));
    tbl.push_back(mk(4, 0, 16'h0,    4'b0111, 4'hA, 0, 0, 0));
    tbl.push_back(mk(2, 1, 16'h1234, 4'b0111, 4'hA, 0, 1, 0));
    tbl.push_back(mk(1, 1, 16'h5678, 4'b0111, 4'hA, 0, 1, 0));
    tbl.push_back(mk(1, 0, 16'h0,    4'b1110, 4'h8, 0, 0, 1));
    tbl.push_back(mk(4, 0, 16'h0,    4'b1101, 4'h7, 0, 0, 0));
    tbl.push_back(mk(4, 0, 16'h0,    4'b1011, 4'h6, 0, 0, 0));
    tbl.push_back(mk(4, 0, 16'h0,    4'b0111, 4'h5, 0, 0, 0));
    tbl.push_back(mk(3, 0, 16'h0,    4'b0111, 4'h5, 0, 0, 0));
    tbl.push_back(mk(1, 1, 16'h00C0, 4'b1110, 4'h0, 0, 0, 1));
    tbl.push_back(mk(4, 0, 16'h0,    4'b1101, 4'hC, 0, 0, 0));
    tbl.push_back(mk(4, 0, 16'h0,    4'b1011, 4'h0, 1, 0, 0));
    tbl.push_back(mk(4, 0, 16'h0,    4'b0111, 4'h0, 1, 0, 0));
    tbl.push_back(mk(1, 1, 16'h0000, 4'b0111, 4'h0, 1, 1, 0));
    tbl.push_back(mk(3, 0, 16'h0,    4'b1110, 4'h0, 0, 0, 1));
    tbl.push_back(mk(4, 0, 16'h0,    4'b1101, 4'h0, 1, 0, 0));

    $display("[TB] start, leading-zero blanking = %0d", LZ);
    rst_n = 1'b0;
    #12;
    checkReset("reset");
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      for (int c = 0; c < tbl[i].n; c++) applyStimulus((c == 0) ? tbl[i].ld : 1'b0, tbl[i].val);
      checkOutput($sformatf("vec%0d sel_n", i), 16'(dig_sel_n), 16'(tbl[i].sel_n));
      checkOutput($sformatf("vec%0d bin", i), 16'(dig_bin), 16'(tbl[i].bin));
      checkOutput($sformatf("vec%0d blank", i), 16'(dig_blank), 16'(LZ ? tbl[i].blank_lz : 1'b0));
      checkOutput($sformatf("vec%0d pending", i), 16'(pending), 16'(tbl[i].pend));
      checkOutput($sformatf("vec%0d frame_done", i), 16'(frame_done), 16'(tbl[i].fd));
    end

    // Reset while digit 2 is lit with a value pending; the pending value must be dropped.
    applyStimulus(1'b1, 16'hBEEF);
    repeat (5) applyStimulus(1'b0, 16'h0);
    checkOutput("pre_rst sel_n", 16'(dig_sel_n), 16'h000B);
    checkOutput("pre_rst pending", 16'(pending), 16'h1);
    #2;
    rst_n = 1'b0;
    #1;
    checkReset("async_rst");
    @(posedge clk);
    #1;
    checkReset("held_rst");
    #2;
    rst_n = 1'b1;
    modelReset();

    for (int i = 0; i < 300; i++) begin
      logic        ld;
      logic [15:0] v;
      v  = 16'($urandom);
      ld = (i >= 20) && ($urandom_range(0, 5) == 0);
      if (i >= 20 && ((e + 1) % FRAME == 0) && $urandom_range(0, 1) == 0) ld = 1'b1;
      if (i >= 20 && $urandom_range(0, 7) == 0) v[15:8] = 8'h00;
      applyStimulus(ld, v);
      modelStep(ld, v);
      checkModel(i);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
